// File: rtl/hit_stream_reducer_pkg.sv
// hit_stream_reducer_pkg: shared hit record, fixed-point type and reducer FSM states
package hit_stream_reducer_pkg;

    // 16.16 signed fixed point ray parameter
    typedef logic signed [31:0] Fixed;

    typedef struct packed {
        logic        bHit;
        Fixed        T;
        logic [15:0] PI;
        logic [3:0]  SurfaceType;
        logic [23:0] Color;
        logic [47:0] normal;
    } HitData;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE,
        S_DONE_EARLY,
        S_DRAIN
    } ReducerState;

    function automatic Fixed FixedInf();
        return 32'sh7FFF_FFFF;
    endfunction

    // Empty slot: no hit, infinitely far, so any real hit wins a strict compare against it
    function automatic HitData NoHit();
        HitData h;
        h   = '0;
        h.T = FixedInf();
        return h;
    endfunction

endpackage

// File: rtl/hit_stream_reducer_min_tree.sv
// hit_stream_reducer_min_tree: combinational log2(LANES)-level min-T tree, lower lane wins ties
module hit_stream_reducer_min_tree
    import hit_stream_reducer_pkg::*;
#(
    parameter int LANES = 4
) (
    input  HitData [LANES-1:0] hit_i,
    output HitData             min_o
);

    HitData [LANES-1:0] lvl;

    // Pairwise reduction per level in place; the right entry replaces the left only when strictly closer
    always_comb begin
        lvl = hit_i;
        for (int w = LANES / 2; w > 0; w = w / 2)
            for (int j = 0; j < w; j++)
                lvl[j] = ($signed(lvl[2*j+1].T) < $signed(lvl[2*j].T)) ? lvl[2*j+1] : lvl[2*j];
    end

    assign min_o = lvl[0];

endmodule

// File: rtl/hit_stream_reducer.sv
// hit_stream_reducer: reduces a multi-beat stream of lane hits for one ray to a closest/any-hit result
module hit_stream_reducer
    import hit_stream_reducer_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int CNT_W     = 16,
    parameter int EARLY_OUT = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  HitData [LANES-1:0] in_hit,
    input  logic               in_last,
    input  logic               mode,
    input  Fixed               max_t,
    output logic               out_valid,
    input  logic               out_ready,
    output HitData             out_hit,
    output logic               out_any,
    output logic [CNT_W-1:0]   out_beats
);

    if (LANES < 1 || LANES > 16 || (LANES & (LANES - 1)) != 0) begin : g_lanes_chk
        $error("hit_stream_reducer: LANES must be a power of two in 1..16");
    end

    ReducerState        state_q, state_d;
    logic               run_q;
    logic               s1_valid_q, s1_last_q;
    HitData             s1_hit_q, acc_q, tree_min;
    HitData [LANES-1:0] qual_hit;
    logic               mode_q;
    Fixed               max_t_q, lim;
    logic [CNT_W-1:0]   beats_q;
    logic               fire, first, load, last_pend, s2_take, early, seen;

    assign fire      = in_valid && in_ready;
    assign first     = state_q == S_IDLE;
    // Only beats of the live ray enter stage 1; discarded beats in early-out states never do
    assign load      = fire && (first || state_q == S_ACCUM);
    // The first beat qualifies against the port value, later beats against the latched one
    assign lim       = first ? max_t : max_t_q;
    // A last beat waiting in stage 1 blocks further input so the next ray cannot overlap it
    assign last_pend = s1_valid_q && s1_last_q;
    assign s2_take   = s1_valid_q && s1_hit_q.bHit && ($signed(s1_hit_q.T) < $signed(acc_q.T));
    assign early     = s1_valid_q && s1_hit_q.bHit && mode_q && (EARLY_OUT != 0);
    assign seen      = last_pend || (fire && in_last);

    // Non-qualifying lanes collapse to the empty hit before the tree
    always_comb begin
        qual_hit = '0;
        for (int k = 0; k < LANES; k++)
            qual_hit[k] = (in_hit[k].bHit && $signed(in_hit[k].T) < $signed(lim)) ? in_hit[k] : NoHit();
    end

    hit_stream_reducer_min_tree #(.LANES(LANES)) u_tree (
        .hit_i (qual_hit),
        .min_o (tree_min)
    );

    // State register; run_q keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state logic; the ray ends when stage 2 sees the last beat or an early any-hit
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       state_d = fire ? S_ACCUM : S_IDLE;
            S_ACCUM:      state_d = last_pend ? S_DONE : early ? S_DONE_EARLY : S_ACCUM;
            S_DONE:       state_d = out_ready ? S_IDLE : S_DONE;
            S_DONE_EARLY: state_d = out_ready ? (seen ? S_IDLE : S_DRAIN) : (seen ? S_DONE : S_DONE_EARLY);
            S_DRAIN:      state_d = (fire && in_last) ? S_IDLE : S_DRAIN;
            default:      state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = run_q && (first || state_q == S_DRAIN ||
                    ((state_q == S_ACCUM || state_q == S_DONE_EARLY) && !last_pend));
        out_valid = state_q == S_DONE || state_q == S_DONE_EARLY;
        out_any   = out_valid && acc_q.bHit;
    end

    // Stage 1 lane-tree register, stage 2 accumulator and per-ray beat counter
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_hit_q   <= NoHit();
            acc_q      <= NoHit();
            beats_q    <= '0;
            mode_q     <= 1'b0;
            max_t_q    <= '0;
        end else begin
            s1_valid_q <= load;
            if (load) begin
                s1_hit_q  <= tree_min;
                s1_last_q <= in_last;
            end
            if (fire && first) begin
                mode_q  <= mode;
                max_t_q <= max_t;
                acc_q   <= NoHit();
                beats_q <= CNT_W'(1);
            end else if (state_q == S_ACCUM) begin
                if (s2_take)
                    acc_q <= s1_hit_q;
                if (fire && beats_q != '1)
                    beats_q <= beats_q + CNT_W'(1);
            end
        end
    end

    assign out_hit   = acc_q;
    assign out_beats = beats_q;

endmodule

// File: tb/tb_hit_stream_reducer.sv
// tb_hit_stream_reducer: directed self-checking bench for the streaming hit reducer
module tb_hit_stream_reducer;
    import hit_stream_reducer_pkg::*;

    typedef HitData [3:0] beat_t;

    localparam logic signed [31:0] INF = 32'sh7FFF_FFFF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready, in_last, mode;
    beat_t       in_hit;
    Fixed        max_t;
    logic        out_valid, out_ready, out_any;
    HitData      out_hit;
    logic [15:0] out_beats;

    int tests = 0;
    int fails = 0;

    hit_stream_reducer #(.LANES(4), .CNT_W(16), .EARLY_OUT(1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_hit    (in_hit),
        .in_last   (in_last),
        .mode      (mode),
        .max_t     (max_t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hit   (out_hit),
        .out_any   (out_any),
        .out_beats (out_beats)
    );

    always #5 clk = ~clk;

    function automatic beat_t mk(input logic [3:0] b, input int t0, input int t1, input int t2, input int t3, input int pib);
        beat_t r;
        int    t [4];
        t = '{t0, t1, t2, t3};
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[k].bHit  = b[k];
            r[k].T     = t[k];
            r[k].PI    = 16'(pib + k);
            r[k].Color = 24'(pib * 7 + k);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded)
    task automatic send_beat(input beat_t b, input logic last, input logic md, input int mt);
        int n;
        in_valid = 1'b1;
        in_hit   = b;
        in_last  = last;
        mode     = md;
        max_t    = mt;
        n        = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        idle();
        out_ready = 1'b0;
        in_hit = '0;
        mode = 1'b0;
        max_t = '0;
        repeat (3) tick();
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_any !== 1'b0 || out_beats !== 16'd0) begin
            fails++;
            $display("FAIL reset_ctrl: in_ready=%0b out_valid=%0b out_any=%0b beats=%0d required 0/0/0/0", in_ready, out_valid, out_any, out_beats);
        end
        tests++;
        if (out_hit.bHit !== 1'b0 || out_hit.T !== INF || out_hit.PI !== 16'd0 || out_hit.Color !== 24'd0) begin
            fails++;
            $display("FAIL reset_hit: bHit=%0b T=%0d PI=%0d Color=%0d required 0/%0d/0/0", out_hit.bHit, out_hit.T, out_hit.PI, out_hit.Color, INF);
        end
        resetn = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_ready: in_ready=%0b required 0", in_ready);
        end
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_release: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_closest_single();
        send_beat(mk(4'b1111, 5, 3, 7, 3, 10), 1'b1, 1'b0, 100);
        idle();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_n1: out_valid=%0b in_ready=%0b required 0/0", out_valid, in_ready);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL single_n2_valid: out_valid=%0b required 1", out_valid);
        end
        tests++;
        if (out_hit.T !== 32'sd3 || out_hit.PI !== 16'd11 || out_hit.bHit !== 1'b1 || out_beats !== 16'd1 || out_any !== 1'b1) begin
            fails++;
            $display("FAIL single_result: T=%0d PI=%0d bHit=%0b beats=%0d any=%0b required 3/11/1/1/1", out_hit.T, out_hit.PI, out_hit.bHit, out_beats, out_any);
        end
        consume();
    endtask

    task automatic test_closest_ties();
        send_beat(mk(4'b1111, 9, 9, 9, 9, 0), 1'b0, 1'b0, 8);
        send_beat(mk(4'b1111, 9, 9, 2, 9, 20), 1'b0, 1'b0, 0);
        send_beat(mk(4'b1111, 2, 9, 9, 9, 30), 1'b1, 1'b0, 0);
        idle();
        wait_out();
        tests++;
        if (out_valid !== 1'b1 || out_hit.T !== 32'sd2 || out_hit.PI !== 16'd22 || out_beats !== 16'd3) begin
            fails++;
            $display("FAIL tie_earlier_beat: valid=%0b T=%0d PI=%0d beats=%0d required 1/2/22/3", out_valid, out_hit.T, out_hit.PI, out_beats);
        end
        consume();
        send_beat(mk(4'b1111, 9, 8, 9, 8, 40), 1'b0, 1'b0, 8);
        send_beat(mk(4'b1111, 8, 9, 12, 9, 50), 1'b1, 1'b0, 8);
        idle();
        wait_out();
        tests++;
        if (out_valid !== 1'b1 || out_hit.bHit !== 1'b0 || out_hit.T !== INF || out_any !== 1'b0 || out_beats !== 16'd2) begin
            fails++;
            $display("FAIL beyond_max_t: valid=%0b bHit=%0b T=%0d any=%0b beats=%0d required 1/0/%0d/0/2", out_valid, out_hit.bHit, out_hit.T, out_any, out_beats, INF);
        end
        consume();
    endtask

    task automatic test_any_hit_early();
        send_beat(mk(4'b0000, 1, 1, 1, 1, 0), 1'b0, 1'b1, 100);
        send_beat(mk(4'b1010, 9, 60, 40, 50, 74), 1'b0, 1'b0, 0);
        idle();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL early_too_soon: out_valid=%0b required 0", out_valid);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_any !== 1'b1 || out_hit.T !== 32'sd50 || out_hit.PI !== 16'd77 || out_beats !== 16'd2 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL early_result: valid=%0b any=%0b T=%0d PI=%0d beats=%0d ready=%0b required 1/1/50/77/2/1", out_valid, out_any, out_hit.T, out_hit.PI, out_beats, in_ready);
        end
        send_beat(mk(4'b0000, 1, 1, 1, 1, 80), 1'b0, 1'b0, 0);
        send_beat(mk(4'b0001, 1, 70, 70, 70, 90), 1'b0, 1'b0, 0);
        idle();
        tests++;
        if (out_valid !== 1'b1 || out_hit.T !== 32'sd50 || out_beats !== 16'd2) begin
            fails++;
            $display("FAIL early_before_last: valid=%0b T=%0d beats=%0d required 1/50/2", out_valid, out_hit.T, out_beats);
        end
        send_beat(mk(4'b1111, 1, 1, 1, 1, 100), 1'b1, 1'b0, 0);
        idle();
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_hit.PI !== 16'd77 || out_beats !== 16'd2) begin
            fails++;
            $display("FAIL early_after_last: valid=%0b ready=%0b PI=%0d beats=%0d required 1/0/77/2", out_valid, in_ready, out_hit.PI, out_beats);
        end
        consume();
        send_beat(mk(4'b1111, 4, 6, 2, 8, 110), 1'b1, 1'b0, 100);
        idle();
        wait_out();
        tests++;
        if (out_valid !== 1'b1 || out_hit.T !== 32'sd2 || out_hit.PI !== 16'd112 || out_beats !== 16'd1) begin
            fails++;
            $display("FAIL early_next_ray: valid=%0b T=%0d PI=%0d beats=%0d required 1/2/112/1", out_valid, out_hit.T, out_hit.PI, out_beats);
        end
        consume();
    endtask

    task automatic test_drain();
        send_beat(mk(4'b0010, 5, 20, 5, 5, 120), 1'b0, 1'b1, 100);
        idle();
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_hit.PI !== 16'd121) begin
            fails++;
            $display("FAIL drain_early: valid=%0b PI=%0d required 1/121", out_valid, out_hit.PI);
        end
        consume();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL drain_state: valid=%0b ready=%0b required 0/1", out_valid, in_ready);
        end
        send_beat(mk(4'b1111, 1, 1, 1, 1, 130), 1'b0, 1'b0, 0);
        send_beat(mk(4'b1111, 1, 1, 1, 1, 140), 1'b1, 1'b0, 0);
        idle();
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL drain_exit: valid=%0b ready=%0b required 0/1", out_valid, in_ready);
        end
        send_beat(mk(4'b0110, 9, 30, 30, 9, 150), 1'b1, 1'b0, 100);
        idle();
        wait_out();
        tests++;
        if (out_valid !== 1'b1 || out_hit.PI !== 16'd151 || out_beats !== 16'd1) begin
            fails++;
            $display("FAIL drain_next_ray: valid=%0b PI=%0d beats=%0d required 1/151/1", out_valid, out_hit.PI, out_beats);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int bad;
        send_beat(mk(4'b1111, 30, 20, 40, 50, 50), 1'b0, 1'b0, 100);
        send_beat(mk(4'b1111, 25, 60, 70, 80, 55), 1'b1, 1'b0, 100);
        idle();
        wait_out();
        in_valid = 1'b1;
        in_hit   = mk(4'b1111, 9, 9, 9, 1, 60);
        in_last  = 1'b1;
        max_t    = 100;
        bad      = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_hit.T !== 32'sd20 || out_hit.PI !== 16'd51 || out_beats !== 16'd2)
                bad++;
            tick();
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL backpressure_stable: %0d unstable cycles, required 0", bad);
        end
        consume();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_beats !== 16'd2) begin
            fails++;
            $display("FAIL handshake_no_accept: valid=%0b ready=%0b beats=%0d required 0/1/2", out_valid, in_ready, out_beats);
        end
        tick();
        idle();
        tests++;
        if (out_beats !== 16'd1) begin
            fails++;
            $display("FAIL next_ray_accept: beats=%0d required 1", out_beats);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_hit.T !== 32'sd1 || out_hit.PI !== 16'd63) begin
            fails++;
            $display("FAIL next_ray_result: valid=%0b T=%0d PI=%0d required 1/1/63", out_valid, out_hit.T, out_hit.PI);
        end
        consume();
    endtask

    task automatic test_no_hit();
        send_beat(mk(4'b0000, 1, 2, 3, 4, 0), 1'b0, 1'b0, 100);
        send_beat(mk(4'b0000, 0, 1, 2, 3, 4), 1'b1, 1'b0, 100);
        idle();
        wait_out();
        tests++;
        if (out_valid !== 1'b1 || out_any !== 1'b0 || out_hit.bHit !== 1'b0 || out_hit.T !== INF || out_beats !== 16'd2) begin
            fails++;
            $display("FAIL no_hit: valid=%0b any=%0b bHit=%0b T=%0d beats=%0d required 1/0/0/%0d/2", out_valid, out_any, out_hit.bHit, out_hit.T, out_beats, INF);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int seen;
        send_beat(mk(4'b1111, 3, 4, 5, 6, 0), 1'b0, 1'b0, 100);
        send_beat(mk(4'b1111, 7, 8, 9, 10, 4), 1'b0, 1'b0, 100);
        idle();
        #1;
        resetn = 1'b1;
        #1;
        tests++;
        if (out_beats !== 16'd0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_hit.T !== INF || out_hit.bHit !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: beats=%0d ready=%0b valid=%0b T=%0d bHit=%0b required 0/0/0/%0d/0", out_beats, in_ready, out_valid, out_hit.T, out_hit.bHit, INF);
        end
        tick();
        resetn = 1'b0;
        seen = 0;
        repeat (4) begin
            tick();
            if (out_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_lost_ray: out_valid seen %0d cycles, required 0", seen);
        end
        send_beat(mk(4'b1111, 7, 7, 7, 7, 40), 1'b1, 1'b0, 100);
        idle();
        wait_out();
        tests++;
        if (out_valid !== 1'b1 || out_hit.PI !== 16'd40 || out_hit.T !== 32'sd7 || out_beats !== 16'd1) begin
            fails++;
            $display("FAIL after_reset_ray: valid=%0b PI=%0d T=%0d beats=%0d required 1/40/7/1", out_valid, out_hit.PI, out_hit.T, out_beats);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_closest_single();
        test_closest_ties();
        test_any_hit_early();
        test_drain();
        test_backpressure();
        test_no_hit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
